// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory slave: word-organised RAM window with configurable wait states and ERROR responses.
// Optional write protection of the top quarter of the window is enabled with `define AHB_MEM_SLAVE_WPROT_EN.
module ahb_mem_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          MEM_DEPTH   = 256,
  parameter int          WAIT_STATES = 0
) (
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic [1:0]  Htrans,
  input  logic        Hwrite,
  input  logic [2:0]  Hsize,
  input  logic [2:0]  Hburst,
  input  logic [31:0] Haddr,
  input  logic [31:0] Hwdata,
  input  logic        Hready_in,
  output logic        Hready_out,
  output logic [1:0]  Hresp,
  output logic [31:0] Hrdata,
  output logic [1:0]  dbg_state
);

  localparam int          AW        = $clog2(MEM_DEPTH);
  localparam logic [32:0] WIN_BYTES = 33'(4 * MEM_DEPTH);
  localparam logic [2:0]  WAIT_LOAD = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
  localparam logic [1:0]  RESP_OKAY = 2'b00;
  localparam logic [1:0]  RESP_ERR  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  state_t          state;
  logic [2:0]      wait_cnt;
  logic            hready_r;
  logic [1:0]      hresp_r;
  logic            dp_active;
  logic            dp_write;
  logic [2:0]      dp_size;
  logic [AW-1:0]   dp_idx;
  logic [1:0]      dp_off;
  logic [31:0]     mem [MEM_DEPTH];

  logic            addr_phase;
  logic [31:0]     offset;
  logic [AW-1:0]   win_idx;
  logic            in_window;
  logic            align_err;
  logic            wprot_err;
  logic            xfer_err;
  logic            commit;
  logic [3:0]      be;
  logic            unused_ok;

  // Handshake: an address phase is accepted when Htrans is NONSEQ/SEQ and both the bus
  // HREADY and our own Hready_out are high; a data phase completes on a cycle with Hready_out=1.
  assign addr_phase = hready_r && Hready_in && Htrans[1];

  assign offset    = Haddr - BASE_ADDR;
  assign win_idx   = offset[AW+1:2];
  assign in_window = (Haddr >= BASE_ADDR) && ({1'b0, offset} < WIN_BYTES);
  assign align_err = (Hsize > 3'b010) ||
                     ((Hsize == 3'b001) && Haddr[0]) ||
                     ((Hsize == 3'b010) && (Haddr[1:0] != 2'b00));

`ifdef AHB_MEM_SLAVE_WPROT_EN
  localparam logic [AW-1:0] PROT_IDX = AW'(3 * MEM_DEPTH / 4);
  assign wprot_err = Hwrite && (win_idx >= PROT_IDX);
`else
  assign wprot_err = 1'b0;
`endif

  assign xfer_err = !in_window || align_err || wprot_err;

  assign unused_ok = ^{Hburst, Htrans[0]};

  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      state     <= ST_IDLE;
      wait_cnt  <= 3'd0;
      hready_r  <= 1'b1;
      hresp_r   <= RESP_OKAY;
      dp_active <= 1'b0;
      dp_write  <= 1'b0;
      dp_size   <= 3'd0;
      dp_idx    <= '0;
      dp_off    <= 2'd0;
    end else begin
      case (state)
        ST_WAIT: begin
          if (wait_cnt == 3'd0) begin
            state    <= ST_IDLE;
            hready_r <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        ST_ERR1: begin
          state    <= ST_ERR2;
          hready_r <= 1'b1;
          hresp_r  <= RESP_ERR;
        end
        default: begin
          // IDLE and ERR2 both have Hready_out=1, so either can accept the next address phase.
          state    <= ST_IDLE;
          hready_r <= 1'b1;
          hresp_r  <= RESP_OKAY;
          if (addr_phase) begin
            if (xfer_err) begin
              state    <= ST_ERR1;
              hready_r <= 1'b0;
              hresp_r  <= RESP_ERR;
            end else if (WAIT_STATES > 0) begin
              state    <= ST_WAIT;
              hready_r <= 1'b0;
              wait_cnt <= WAIT_LOAD;
            end
          end
        end
      endcase

      if (addr_phase) begin
        dp_active <= !xfer_err;
        dp_write  <= Hwrite;
        dp_size   <= Hsize;
        dp_idx    <= win_idx;
        dp_off    <= Haddr[1:0];
      end else if (hready_r) begin
        dp_active <= 1'b0;
      end
    end
  end

  always_comb begin
    be = 4'b0000;
    case (dp_size)
      3'b000:  be[dp_off] = 1'b1;
      3'b001:  be = dp_off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  assign commit = Hresetn && dp_active && dp_write && hready_r;

  // Memory is deliberately left out of reset.
  always_ff @(posedge Hclk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[dp_idx][8*b +: 8] <= Hwdata[8*b +: 8];
      end
    end
  end

  assign Hready_out = hready_r;
  assign Hresp      = hresp_r;
  assign Hrdata     = (dp_active && !dp_write && hready_r) ? mem[dp_idx] : 32'h0;
  assign dbg_state  = state;

endmodule

// File: doc/ahb_mem_slave.md
AHB_MEM_SLAVE -- requirements
Module: ahb_mem_slave

Interface
REQ-001 The module SHALL have parameter BASE_ADDR, default 32'h8000_0000, giving the start of the decoded address window.
REQ-002 The module SHALL have parameter MEM_DEPTH, default 256, giving the number of 32-bit words in the window (power of 2).
REQ-003 The module SHALL have parameter WAIT_STATES, default 0, range 0..7, giving Hready_out-low cycles per OKAY data phase.
REQ-004 Hclk  input  1  the only clock; all state updates on its rising edge.
REQ-005 Hresetn  input  1  reset, synchronous and active-low.
REQ-006 Htrans  input  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-007 Hwrite  input  1  direction: 1 write, 0 read.
REQ-008 Hsize  input  3  transfer size: 000 byte, 001 half-word, 010 word.
REQ-009 Hburst  input  3  burst type; accepted but not otherwise used.
REQ-010 Haddr  input  32  byte address.
REQ-011 Hwdata  input  32  write data, valid in the data phase.
REQ-012 Hready_in  input  1  bus HREADY; an address phase is sampled only when it is 1.
REQ-013 Hready_out  output  1  slave ready: 0 inserts a wait state.
REQ-014 Hresp  output  2  response: 00 OKAY, 01 ERROR.
REQ-015 Hrdata  output  32  read data.

Function
REQ-016 An active transfer SHALL be sampled at a rising edge where Hready_in=1 and Htrans[1]=1, capturing Haddr, Hwrite and Hsize.
REQ-017 IDLE and BUSY transfers SHALL get a zero-wait OKAY response with no memory access.
REQ-018 A sampled transfer SHALL be in error if any of these hold: Haddr outside [BASE_ADDR, BASE_ADDR+4*MEM_DEPTH-1]; Hsize>010; half-word with Haddr[0]=1; word with Haddr[1:0]!=00.
REQ-019 The state machine SHALL have states IDLE, WAIT, ERR1 and ERR2.
REQ-020 IDLE -> WAIT on a valid transfer when WAIT_STATES>0; IDLE -> ERR1 on an erroneous transfer; otherwise stay in IDLE.
REQ-021 WAIT SHALL count WAIT_STATES cycles with Hready_out=0 and Hresp=00, then return to IDLE with Hready_out=1 for the completing cycle.
REQ-022 ERR1 SHALL drive Hready_out=0 and Hresp=01 for one cycle, then go to ERR2.
REQ-023 ERR2 SHALL drive Hready_out=1 and Hresp=01 for one cycle, then go to IDLE; an address phase sampled during ERR2 SHALL be processed normally.
REQ-024 While Hready_out=0, no new address phase SHALL be sampled.
REQ-025 A write SHALL commit to memory at the edge ending its data phase (Hready_out=1), using little-endian byte lanes.
REQ-026 Byte lane select: byte writes Hwdata[8*a+7:8*a] with a=Haddr[1:0]; half-word writes Hwdata[16*Haddr[1]+15:16*Haddr[1]].
REQ-027 Hrdata SHALL present the full memory word at the captured address, combinationally, during the completing cycle of a read data phase, and 0 at all other times.
REQ-028 A read whose address phase coincides with a preceding write's completing cycle SHALL return the newly written data.
REQ-029 Word index SHALL be (Haddr-BASE_ADDR)>>2, truncated to log2(MEM_DEPTH) bits.
REQ-030 Erroneous transfers SHALL never modify memory.

Reset
REQ-031 While Hresetn=0 at a rising edge: state=IDLE, wait counter=0, Hready_out=1, Hresp=00, Hrdata=0, captured transfer cleared.
REQ-032 Reset asserted mid-WAIT or mid-ERR SHALL abort the transfer with no memory write.
REQ-033 Memory contents SHALL NOT be reset.

Configuration
REQ-034 Macro AHB_MEM_SLAVE_WPROT_EN: when defined, a write to the top quarter of the window (word index >= 3*MEM_DEPTH/4) SHALL be erroneous (ERR1/ERR2, no write), and reads there SHALL remain OKAY.
REQ-035 Without AHB_MEM_SLAVE_WPROT_EN, the whole window SHALL be writable.

Verification
REQ-036 WAIT_STATES=0: word write 32'hDEAD_BEEF to 0x8000_0010, then a read of 0x8000_0010 -> OKAY, zero waits, Hrdata=32'hDEAD_BEEF.
REQ-037 WAIT_STATES=2: NONSEQ read -> Hready_out sequence 0,0,1 with Hresp=00 throughout.
REQ-038 Word write to 0x8000_0002 -> Hready_out/Hresp = 0/01 then 1/01; a subsequent read of word 0x8000_0000 is unchanged.
REQ-039 Word write 32'h0 to 0x8000_0004, then byte write 32'h00AB_0000 to 0x8000_0006 -> word read of 0x8000_0004 = 32'h00AB_0000.
REQ-040 Hresetn=0 for one cycle during the second wait of a WAIT_STATES=3 write -> Hready_out=1, Hresp=00 on the next cycle, and no memory update.
REQ-041 With AHB_MEM_SLAVE_WPROT_EN defined: write to 0x8000_0300 -> ERROR; read of 0x8000_0300 -> OKAY.
